// File: rtl/pearson_sched.sv
// rtl/pearson_sched.sv - round-robin sequencer sharing one Pearson hash engine among requesters
//
// Purpose:
//   Arbitrates N_REQ requesters onto a single Pearson hash datapath.
//   The granted requester streams its message bytes one per cycle
//   through the recurrence h := T[h xor c]. The permutation table T is
//   an external asynchronous-read RAM. The final hash is returned with
//   the owning requester ID over a valid/ready handshake.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   ID_W   requester ID width, ceil(log2(N_REQ))
//   LEN_W  message length field width
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       asynchronous active-high reset
//   req_i         per-requester request level
//   len_i         per-requester message length, slice k = requester k
//   gnt_o         one-hot grant, held through HASH and DONE
//   byte_i        per-requester message byte, slice k = requester k
//   byte_valid_i  per-requester byte valid
//   byte_rd_o     byte ready, only the granted bit and only in HASH
//   tbl_addr_o    table address, h xor selected byte in HASH, else 0
//   tbl_data_i    table read data for tbl_addr_o, same cycle
//   hash_valid_o  hash result valid (DONE)
//   hash_o        hash result
//   hash_id_o     requester owning hash_o
//   hash_ready_i  consumer accepts the result
//   busy_o        high whenever the sequencer is not idle

module pearson_sched #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int LEN_W = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LEN_W-1:0] len_i,
    output logic [N_REQ-1:0]       gnt_o,
    input  logic [N_REQ*8-1:0]     byte_i,
    input  logic [N_REQ-1:0]       byte_valid_i,
    output logic [N_REQ-1:0]       byte_rd_o,
    output logic [7:0]             tbl_addr_o,
    input  logic [7:0]             tbl_data_i,
    output logic                   hash_valid_o,
    output logic [7:0]             hash_o,
    output logic [ID_W-1:0]        hash_id_o,
    input  logic                   hash_ready_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HASH = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_h;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_byte_rd;
    logic               r_hash_valid;
    logic [7:0]         r_hash;
    logic [ID_W-1:0]    r_hash_id;
    logic               r_busy;

    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic [LEN_W-1:0]   w_win_len;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [7:0]         w_sel_byte;
    logic               w_sel_valid;
    logic               w_accept;
    logic               w_last;
    logic [ID_W-1:0]    w_next_ptr;

    // Round-robin scan: priority order is ptr, ptr+1, ... wrapping at N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_found && (k == ((int'(r_ptr) + i) % N_REQ)) && req_i[k]) begin
                    w_found  = 1'b1;
                    w_win_id = ID_W'(k);
                end
            end
        end
    end

    // Length slice of the arbitration winner.
    always_comb begin
        w_win_len = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == w_win_id) begin
                w_win_len = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    assign w_win_onehot = N_REQ'(1) << w_win_id;

    // Byte lane of the currently granted requester.
    always_comb begin
        w_sel_byte  = 8'h00;
        w_sel_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == r_id) begin
                w_sel_byte  = byte_i[k*8 +: 8];
                w_sel_valid = byte_valid_i[k];
            end
        end
    end

    assign w_accept   = (r_state == S_HASH) && w_sel_valid;
    assign w_last     = (r_cnt == (r_len - LEN_W'(1)));
    assign w_next_ptr = (int'(r_id) == N_REQ - 1) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_h          <= 8'h00;
            r_cnt        <= '0;
            r_len        <= '0;
            r_id         <= '0;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_byte_rd    <= '0;
            r_hash_valid <= 1'b0;
            r_hash       <= 8'h00;
            r_hash_id    <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id   <= w_win_id;
                        r_len  <= w_win_len;
                        r_h    <= 8'h00;
                        r_cnt  <= '0;
                        r_gnt  <= w_win_onehot;
                        r_busy <= 1'b1;
                        if (w_win_len != '0) begin
                            r_state   <= S_HASH;
                            r_byte_rd <= w_win_onehot;
                        end else begin
                            // Empty message: the hash is the initial value.
                            r_state      <= S_DONE;
                            r_hash_valid <= 1'b1;
                            r_hash       <= 8'h00;
                            r_hash_id    <= w_win_id;
                        end
                    end
                end

                S_HASH: begin
                    if (w_accept) begin
                        r_h   <= tbl_data_i;
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_byte_rd    <= '0;
                            r_hash_valid <= 1'b1;
                            r_hash       <= tbl_data_i;
                            r_hash_id    <= r_id;
                        end
                    end
                end

                S_DONE: begin
                    if (hash_ready_i) begin
                        r_state      <= S_IDLE;
                        r_ptr        <= w_next_ptr;
                        r_gnt        <= '0;
                        r_hash_valid <= 1'b0;
                        r_hash       <= 8'h00;
                        r_hash_id    <= '0;
                        r_busy       <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_gnt     <= '0;
                    r_byte_rd <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Table address is combinational so the table answers in the same cycle.
    assign tbl_addr_o   = (r_state == S_HASH) ? (r_h ^ w_sel_byte) : 8'h00;

    assign gnt_o        = r_gnt;
    assign byte_rd_o    = r_byte_rd;
    assign hash_valid_o = r_hash_valid;
    assign hash_o       = r_hash;
    assign hash_id_o    = r_hash_id;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_pearson_sched.sv
// tb/tb_pearson_sched.sv - directed self-checking bench for pearson_sched

module tb_pearson_sched;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;
    localparam int LEN_W = 4;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*LEN_W-1:0] len_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ*8-1:0]     byte_i;
    logic [N_REQ-1:0]       byte_valid_i;
    logic [N_REQ-1:0]       byte_rd_o;
    logic [7:0]             tbl_addr_o;
    logic [7:0]             tbl_data_i;
    logic                   hash_valid_o;
    logic [7:0]             hash_o;
    logic [ID_W-1:0]        hash_id_o;
    logic                   hash_ready_i;
    logic                   busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    // Table model T[x] = (x+1) mod 256.
    assign tbl_data_i = tbl_addr_o + 8'h01;

    pearson_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .len_i        (len_i),
        .gnt_o        (gnt_o),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_rd_o    (byte_rd_o),
        .tbl_addr_o   (tbl_addr_o),
        .tbl_data_i   (tbl_data_i),
        .hash_valid_o (hash_valid_o),
        .hash_o       (hash_o),
        .hash_id_o    (hash_id_o),
        .hash_ready_i (hash_ready_i),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},   32'(gnt_o),        32'h0);
        chk({tag, "_rd"},    32'(byte_rd_o),    32'h0);
        chk({tag, "_valid"}, 32'(hash_valid_o), 32'h0);
        chk({tag, "_hash"},  32'(hash_o),       32'h0);
        chk({tag, "_id"},    32'(hash_id_o),    32'h0);
        chk({tag, "_busy"},  32'(busy_o),       32'h0);
        chk({tag, "_addr"},  32'(tbl_addr_o),   32'h0);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i      = 1'b1;
        req_i        = '0;
        len_i        = '0;
        byte_i       = '0;
        byte_valid_i = '0;
        hash_ready_i = 1'b0;
        tick;
        tick;
        chk_idle("reset");
        reset_i = 1'b0;
        tick;
        chk_idle("post_reset");

        // Single byte: requester 0, len 1, byte 0x5A -> 0x5B.
        req_i = 2'b01; len_i = {4'd0, 4'd1}; byte_i = {8'h00, 8'h5A}; byte_valid_i = 2'b01;
        tick;
        chk("t1_gnt",   32'(gnt_o),        32'h1);
        chk("t1_busy",  32'(busy_o),       32'h1);
        chk("t1_rd",    32'(byte_rd_o),    32'h1);
        chk("t1_addr",  32'(tbl_addr_o),   32'h5A);
        chk("t1_nv",    32'(hash_valid_o), 32'h0);
        req_i = '0;
        tick;
        chk("t1_valid", 32'(hash_valid_o), 32'h1);
        chk("t1_hash",  32'(hash_o),       32'h5B);
        chk("t1_id",    32'(hash_id_o),    32'h0);
        chk("t1_rd0",   32'(byte_rd_o),    32'h0);
        chk("t1_addr0", 32'(tbl_addr_o),   32'h0);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;
        chk("t1_idle_busy", 32'(busy_o),       32'h0);
        chk("t1_idle_gnt",  32'(gnt_o),        32'h0);
        chk("t1_idle_v",    32'(hash_valid_o), 32'h0);

        // Two-byte chain: requester 1, bytes 00,00 -> T[T[0]^0] = 0x02.
        req_i = 2'b10; len_i = {4'd2, 4'd0}; byte_i = {8'h00, 8'h00}; byte_valid_i = 2'b10;
        tick;
        req_i = '0;
        chk("t2_gnt",   32'(gnt_o),      32'h2);
        chk("t2_rd",    32'(byte_rd_o),  32'h2);
        chk("t2_addr0", 32'(tbl_addr_o), 32'h00);
        tick;
        chk("t2_addr1", 32'(tbl_addr_o),   32'h01);
        chk("t2_nv",    32'(hash_valid_o), 32'h0);
        tick;
        chk("t2_valid", 32'(hash_valid_o), 32'h1);
        chk("t2_hash",  32'(hash_o),       32'h02);
        chk("t2_id",    32'(hash_id_o),    32'h1);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;

        // Table wrap: requester 0, byte 0xFF -> 0x00.
        req_i = 2'b01; len_i = {4'd0, 4'd1}; byte_i = {8'h00, 8'hFF}; byte_valid_i = 2'b01;
        tick;
        req_i = '0;
        chk("t3_addr", 32'(tbl_addr_o), 32'hFF);
        tick;
        chk("t3_valid", 32'(hash_valid_o), 32'h1);
        chk("t3_hash",  32'(hash_o),       32'h00);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;

        // Zero length with backpressure: requester 1 (ptr is now 1).
        req_i = 2'b10; len_i = {4'd0, 4'd0}; byte_i = {8'h77, 8'h00}; byte_valid_i = 2'b10;
        tick;
        req_i = '0;
        chk("t4_valid", 32'(hash_valid_o), 32'h1);
        chk("t4_hash",  32'(hash_o),       32'h00);
        chk("t4_id",    32'(hash_id_o),    32'h1);
        chk("t4_gnt",   32'(gnt_o),        32'h2);
        chk("t4_rd",    32'(byte_rd_o),    32'h0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t4_hold_valid", 32'(hash_valid_o), 32'h1);
            chk("t4_hold_hash",  32'(hash_o),       32'h00);
            chk("t4_hold_id",    32'(hash_id_o),    32'h1);
            chk("t4_hold_rd",    32'(byte_rd_o),    32'h0);
        end
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;
        chk("t4_idle", 32'(busy_o), 32'h0);

        // Byte-stream gaps: requester 0, bytes 10,20,30.
        // h: 0 -> T[10]=11 -> T[11^20=31]=32 -> T[32^30=02]=03.
        req_i = 2'b01; len_i = {4'd0, 4'd3}; byte_i = {8'h00, 8'h10}; byte_valid_i = 2'b01;
        tick;
        req_i = '0;
        chk("t5_addr0", 32'(tbl_addr_o), 32'h10);
        tick;
        byte_valid_i = 2'b00; byte_i = {8'h00, 8'h20};
        #1;
        chk("t5_addr1", 32'(tbl_addr_o), 32'h31);
        tick;
        chk("t5_gap1a", 32'(tbl_addr_o), 32'h31);
        tick;
        chk("t5_gap1b", 32'(tbl_addr_o),   32'h31);
        chk("t5_gap1v", 32'(hash_valid_o), 32'h0);
        byte_valid_i = 2'b01;
        tick;
        byte_valid_i = 2'b00; byte_i = {8'h00, 8'h30};
        #1;
        chk("t5_addr2", 32'(tbl_addr_o),   32'h02);
        chk("t5_nv2",   32'(hash_valid_o), 32'h0);
        tick;
        tick;
        chk("t5_gap2",  32'(tbl_addr_o),   32'h02);
        chk("t5_gap2v", 32'(hash_valid_o), 32'h0);
        byte_valid_i = 2'b01;
        tick;
        chk("t5_valid", 32'(hash_valid_o), 32'h1);
        chk("t5_hash",  32'(hash_o),       32'h03);
        chk("t5_id",    32'(hash_id_o),    32'h0);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;

        // Round robin after reset: simultaneous requests, held high throughout.
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        req_i = 2'b11; len_i = {4'd1, 4'd1}; byte_i = {8'h02, 8'h01}; byte_valid_i = 2'b11;
        tick;
        chk("rr_gnt0", 32'(gnt_o), 32'h1);
        tick;
        chk("rr_oh0",  32'($onehot0(gnt_o)), 32'h1);
        chk("rr_id0",  32'(hash_id_o), 32'h0);
        chk("rr_h0",   32'(hash_o),    32'h02);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;
        chk("rr_gap_gnt", 32'(gnt_o), 32'h0);
        tick;
        chk("rr_gnt1", 32'(gnt_o), 32'h2);
        tick;
        chk("rr_oh1",  32'($onehot0(gnt_o)), 32'h1);
        chk("rr_id1",  32'(hash_id_o), 32'h1);
        chk("rr_h1",   32'(hash_o),    32'h03);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;
        tick;
        chk("rr_gnt2", 32'(gnt_o), 32'h1);
        req_i = '0;
        tick;
        chk("rr_id2",  32'(hash_id_o), 32'h0);
        chk("rr_h2",   32'(hash_o),    32'h02);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;

        // Reset mid-message, then a fresh message.
        req_i = 2'b01; len_i = {4'd0, 4'd4}; byte_i = {8'h00, 8'h00}; byte_valid_i = 2'b01;
        tick;
        req_i = '0;
        tick;
        tick;
        chk("rm_busy_pre", 32'(busy_o), 32'h1);
        reset_i = 1'b1;
        #1;
        chk_idle("rm_async");
        tick;
        reset_i = 1'b0;
        req_i = 2'b01; len_i = {4'd0, 4'd1}; byte_i = {8'h00, 8'h00}; byte_valid_i = 2'b01;
        tick;
        req_i = '0;
        chk("rm_gnt", 32'(gnt_o), 32'h1);
        tick;
        chk("rm_valid", 32'(hash_valid_o), 32'h1);
        chk("rm_hash",  32'(hash_o),       32'h01);
        chk("rm_id",    32'(hash_id_o),    32'h0);
        hash_ready_i = 1'b1;
        tick;
        hash_ready_i = 1'b0;
        chk("rm_end", 32'(busy_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
